// File: rtl/mcc_run_pkg.sv
// rtl/mcc_run_pkg.sv - shared state type and default constants for the run controller
//
// Shared by mcc_run_ctrl and its testbench. Holds the controller state
// enumeration and the default values of the top-level parameters.
package mcc_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_e;

  localparam int DEF_DATA_BUS_WIDTH = 32;
  localparam int DEF_RESET_CYCLES   = 5;
  localparam int DEF_RUN_CYCLES     = 401;
  localparam int DEF_TRACE_DEPTH    = 16;
  localparam int DEF_CYC_W          = 16;

endpackage

// File: rtl/mcc_trace_fifo.sv
// rtl/mcc_trace_fifo.sv - trace FIFO with sticky drop flag and zero-latency head
//
// Ports:
//   clock, reset  : clock, asynchronous active-low reset
//   clear         : synchronous flush (pointers and overflow)
//   push/push_data: write request; dropped when full unless a pop happens too
//   pop           : remove head entry (ignored when empty)
//   head_data     : current head entry, read combinationally from storage
//   full, empty   : occupancy status
//   overflow      : sticky, set when a push is dropped; cleared by clear/reset
module mcc_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty; DEPTH is a power of
  // two, so the low bits wrap modulo DEPTH on their own.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot in the same edge, so a full FIFO still accepts
  // a push when it is also being popped.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)    overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mcc_run_ctrl.sv
// rtl/mcc_run_ctrl.sv - computer run sequencer with change-only output trace
//
// Holds the computer in reset for RESET_CYCLES, releases it for RUN_CYCLES,
// then parks in DONE. During RUN, program_out is traced into a FIFO on the
// first cycle and whenever it changes.
// Optional feature macro: MCC_RUN_CTRL_TIMESTAMP_EN prefixes each trace
// entry with the RUN-cycle index.
//
// Ports:
//   clock, reset  : clock, asynchronous active-low reset
//   start         : one-cycle run request (honoured in IDLE/DONE only)
//   program_out   : computer output being traced
//   cpu_reset     : active-high reset to the computer (low only in RUN)
//   running, done : state indicators
//   overflow      : sticky trace-drop flag
//   trace_valid/trace_data/trace_ready : trace stream to the consumer
module mcc_run_ctrl
  import mcc_run_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int RUN_CYCLES     = DEF_RUN_CYCLES,
  parameter int TRACE_DEPTH    = DEF_TRACE_DEPTH,
  parameter int CYC_W          = DEF_CYC_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_BUS_WIDTH-1:0] program_out,
  output logic                      cpu_reset,
  output logic                      running,
  output logic                      done,
  output logic                      overflow,
  output logic                      trace_valid,
`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
  output logic [CYC_W+DATA_BUS_WIDTH-1:0] trace_data,
`else
  output logic [DATA_BUS_WIDTH-1:0]       trace_data,
`endif
  input  logic                      trace_ready
);

`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
  localparam int TW = CYC_W + DATA_BUS_WIDTH;
`else
  localparam int TW = DATA_BUS_WIDTH;
`endif

  localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(RUN_CYCLES - 1);

  run_state_e                state;
  run_state_e                state_nxt;
  logic [CYC_W-1:0]          cyc_cnt;
  logic [CYC_W-1:0]          cyc_nxt;
  logic [DATA_BUS_WIDTH-1:0] prev_sample;
  logic                      trace_clear;
  logic                      trace_push;
  logic                      trace_pop;
  logic [TW-1:0]             trace_entry;
  logic                      fifo_empty;
  logic                      unused_fifo_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      prev_sample <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      if (state == RUN) prev_sample <= program_out;
    end
  end

  // cyc_cnt restarts at 0 on every state entry, so in RUN it is the
  // 0-based RUN-cycle index used for the first-cycle push and timestamp.
  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc_cnt;
    trace_clear = 1'b0;
    cpu_reset   = 1'b1;
    running     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt   = HOLD;
          cyc_nxt     = '0;
          trace_clear = 1'b1;
        end
      end
      HOLD: begin
        if (cyc_cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        running   = 1'b1;
        if (cyc_cnt == RUN_LAST) begin
          state_nxt = DONE;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign trace_push  = (state == RUN) && ((cyc_cnt == '0) || (program_out != prev_sample));
  assign trace_pop   = trace_valid && trace_ready;
  assign trace_valid = !fifo_empty;

`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
  assign trace_entry = {cyc_cnt, program_out};
`else
  assign trace_entry = program_out;
`endif

  mcc_trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (trace_clear),
    .push      (trace_push),
    .push_data (trace_entry),
    .pop       (trace_pop),
    .head_data (trace_data),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_mcc_run_ctrl.sv
// tb/tb_mcc_run_ctrl.sv - self-checking scoreboard bench for mcc_run_ctrl
module tb_mcc_run_ctrl;

  localparam int DW     = 32;
  localparam int CW     = 16;
  localparam int HOLD_N = 5;
  localparam int RUN_N  = 401;
  localparam int DEPTH  = 4;
`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
  localparam int TW = CW + DW;
`else
  localparam int TW = DW;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          trace_ready = 1'b0;
  logic [DW-1:0] program_out = '0;
  logic          cpu_reset;
  logic          running;
  logic          done;
  logic          overflow;
  logic          trace_valid;
  logic [TW-1:0] trace_data;

  always #5 clock = ~clock;

  mcc_run_ctrl #(
    .DATA_BUS_WIDTH (DW),
    .RESET_CYCLES   (HOLD_N),
    .RUN_CYCLES     (RUN_N),
    .TRACE_DEPTH    (DEPTH),
    .CYC_W          (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .program_out (program_out),
    .cpu_reset   (cpu_reset),
    .running     (running),
    .done        (done),
    .overflow    (overflow),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trace_ready (trace_ready)
  );

  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] exp_q[$];
  bit            m_ovf  = 1'b0;
  int            m_step = -1;   // edges since the accepted start edge, -1 when idle
  logic [DW-1:0] m_prev = '0;

  function automatic logic [TW-1:0] make_entry(input int idx, input logic [DW-1:0] v);
`ifdef MCC_RUN_CTRL_TIMESTAMP_EN
    logic [CW-1:0] ts;
    ts = CW'(idx);
    return {ts, v};
`else
    return TW'(v + DW'(idx) * 0);
`endif
  endfunction

  // Drive one cycle: model the edge, pop-check the scoreboard head, then
  // compare the post-edge outputs against the model.
  task automatic tick(input logic [DW-1:0] po, input bit rdy, input bit st);
    bit in_run, do_pop, do_push, clr, exp_run, exp_done;
    int idx, sz;
    program_out = po;
    trace_ready = rdy;
    start       = st;
    in_run  = (m_step >= HOLD_N) && (m_step < HOLD_N + RUN_N);
    idx     = m_step - HOLD_N;
    do_pop  = rdy && (exp_q.size() != 0);
    if (do_pop) begin
      checks++;
      if (trace_data !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_data: got %h expected %h (step %0d)", trace_data, exp_q[0], m_step);
      end
    end
    do_push = in_run && ((idx == 0) || (po != m_prev));
    if (in_run) m_prev = po;
    clr = st && ((m_step < 0) || (m_step >= HOLD_N + RUN_N));
    if (clr) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_step = 0;
    end else begin
      sz = exp_q.size();
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if ((sz < DEPTH) || do_pop) exp_q.push_back(make_entry(idx, po));
        else m_ovf = 1'b1;
      end
      if (m_step >= 0) m_step++;
    end
    @(posedge clock);
    #1;
    start    = 1'b0;
    exp_run  = (m_step >= HOLD_N) && (m_step < HOLD_N + RUN_N);
    exp_done = (m_step >= HOLD_N + RUN_N);
    checks++;
    if (cpu_reset !== !exp_run) begin
      errors++;
      $display("FAIL cpu_reset: got %b expected %b (step %0d)", cpu_reset, !exp_run, m_step);
    end
    checks++;
    if (running !== exp_run) begin
      errors++;
      $display("FAIL running: got %b expected %b (step %0d)", running, exp_run, m_step);
    end
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL done: got %b expected %b (step %0d)", done, exp_done, m_step);
    end
    checks++;
    if (trace_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL trace_valid: got %b expected %b (step %0d)", trace_valid, exp_q.size() != 0, m_step);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow: got %b expected %b (step %0d)", overflow, m_ovf, m_step);
    end
  endtask

  // Pop with trace_ready=1 while trace_valid is seen; bounded.
  task automatic drain(output int n);
    n = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      if (!trace_valid) break;
      n++;
      tick(program_out, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || running !== 1'b0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got cpu_reset=%b running=%b valid=%b ovf=%b expected 1 0 0 0",
               cpu_reset, running, trace_valid, overflow);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got cpu_reset=%b running=%b done=%b valid=%b ovf=%b expected 1 0 0 0 0",
               cpu_reset, running, done, trace_valid, overflow);
    end
  endtask

  task automatic test_run_constant();
    int hi, lo, phase, n;
    tick(32'h0000_0007, 1'b0, 1'b1);
    hi = 0; lo = 0; phase = 0;
    for (int c = 0; c < HOLD_N + RUN_N + 3; c++) begin
      if (phase == 0) begin
        if (cpu_reset) hi++;
        else begin phase = 1; lo = 1; end
      end else if (phase == 1) begin
        if (!cpu_reset) lo++;
        else phase = 2;
      end
      tick(32'h0000_0007, 1'b0, 1'b0);
    end
    checks++;
    if (hi != HOLD_N) begin
      errors++;
      $display("FAIL hold_length: got %0d expected %0d", hi, HOLD_N);
    end
    checks++;
    if (lo != RUN_N) begin
      errors++;
      $display("FAIL run_length: got %0d expected %0d", lo, RUN_N);
    end
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL done_state: got done=%b cpu_reset=%b expected 1 1", done, cpu_reset);
    end
    checks++;
    if (trace_data !== make_entry(0, 32'h0000_0007)) begin
      errors++;
      $display("FAIL const_head: got %h expected %h", trace_data, make_entry(0, 32'h0000_0007));
    end
    drain(n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL const_count: got %0d expected 1", n);
    end
  endtask

  task automatic test_overflow();
    int n;
    tick('0, 1'b0, 1'b1);
    for (int c = 0; c < HOLD_N + RUN_N; c++)
      tick((m_step >= HOLD_N) ? DW'(m_step - HOLD_N) : '0, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    checks++;
    if (trace_data !== make_entry(0, '0)) begin
      errors++;
      $display("FAIL ovf_head: got %h expected %h", trace_data, make_entry(0, '0));
    end
    drain(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL ovf_count: got %0d expected %0d", n, DEPTH);
    end
    checks++;
    if (trace_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drain: got valid=%b ovf=%b expected 0 1", trace_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int idx, n;
    tick('0, 1'b0, 1'b1);
    for (int c = 0; c < HOLD_N + RUN_N; c++) begin
      idx = m_step - HOLD_N;
      tick((idx < 0) ? '0 : ((idx <= 8) ? DW'(idx) : DW'(8)), (idx >= 4) && (idx <= 8), 1'b0);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fpp_overflow: got %b expected 0", overflow);
    end
    checks++;
    if (trace_data !== make_entry(5, 32'd5)) begin
      errors++;
      $display("FAIL fpp_head: got %h expected %h", trace_data, make_entry(5, 32'd5));
    end
    drain(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL fpp_count: got %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_mid_run_reset();
    int idx, n;
    tick('0, 1'b0, 1'b1);
    for (int c = 0; c < HOLD_N + 100; c++)
      tick((m_step >= HOLD_N) ? DW'(m_step - HOLD_N) : '0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || running !== 1'b0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cpu_reset=%b running=%b valid=%b ovf=%b expected 1 0 0 0",
               cpu_reset, running, trace_valid, overflow);
    end
    exp_q.delete();
    m_ovf  = 1'b0;
    m_step = -1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick('0, 1'b0, 1'b0);
    // Fresh run with stray start pulses in HOLD and RUN and a random consumer.
    tick(32'd5, 1'b0, 1'b1);
    for (int c = 0; c < HOLD_N + RUN_N + 1; c++) begin
      idx = m_step - HOLD_N;
      tick((idx < 0) ? DW'(5) : DW'((idx / 37) * 3 + ((idx % 97) == 0 ? 1 : 0)),
           $urandom_range(0, 3) == 0, (m_step == 2) || (m_step == 200));
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL fresh_done: got %b expected 1", done);
    end
    drain(n);
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL fresh_drain: got valid=%b expected 0 after %0d pops", trace_valid, n);
    end
  endtask

  initial begin
    test_reset();
    test_run_constant();
    test_overflow();
    test_full_push_pop();
    test_mid_run_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcc_run_ctrl.md
MCC_RUN_CTRL -- requirements
Module: mcc_run_ctrl

Interface
- REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 32: width of the computer's program_out bus.
- REQ-002 SHALL have parameter RESET_CYCLES, default 5: number of cycles cpu_reset is held before a run.
- REQ-003 SHALL have parameter RUN_CYCLES, default 401: number of cycles in a run.
- REQ-004 SHALL have parameter TRACE_DEPTH, default 16 (power of two, >=2): number of trace FIFO entries.
- REQ-005 SHALL have parameter CYC_W, default 16: cycle-counter width; RESET_CYCLES and RUN_CYCLES must be < 2^CYC_W.
- REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-008 SHALL have port start, input, 1 bit: one-cycle run request.
- REQ-009 SHALL have port program_out, input, DATA_BUS_WIDTH bits: computer output being traced.
- REQ-010 SHALL have port cpu_reset, output, 1 bit: active-high reset driven to the computer.
- REQ-011 SHALL have port running, output, 1 bit: high in RUN.
- REQ-012 SHALL have port done, output, 1 bit: high in DONE.
- REQ-013 SHALL have port overflow, output, 1 bit: sticky trace-drop flag.
- REQ-014 SHALL have port trace_valid, output, 1 bit: trace entry available.
- REQ-015 SHALL have port trace_data, output, TW bits: head trace entry; TW is defined in REQ-032 and REQ-033.
- REQ-016 SHALL have port trace_ready, input, 1 bit: consumer accepts the entry.

Function
- REQ-017 SHALL implement states IDLE, HOLD, RUN, DONE.
- REQ-018 SHALL drive cpu_reset=1 in IDLE, HOLD and DONE, and cpu_reset=0 in RUN.
- REQ-019 SHALL go from IDLE or DONE to HOLD on start=1, clearing the cycle counter, overflow and the trace FIFO in the same edge.
- REQ-020 SHALL ignore start in HOLD and RUN.
- REQ-021 SHALL stay in HOLD for exactly RESET_CYCLES cycles, then enter RUN.
- REQ-022 SHALL stay in RUN for exactly RUN_CYCLES cycles, then enter DONE.
- REQ-023 SHALL, in RUN, push program_out on the first RUN cycle and on every later RUN cycle where it differs from the previous cycle's sample.
- REQ-024 SHALL, when a push is due, the FIFO is full, and no pop occurs in that cycle, drop the entry and set overflow, which holds until the next start or reset.
- REQ-025 SHALL, on a simultaneous push and pop while full, perform both operations without setting overflow.
- REQ-026 SHALL pop an entry when trace_valid and trace_ready are both 1, in any state.
- REQ-027 SHALL drive trace_valid=1 whenever the FIFO is non-empty.
- REQ-028 SHALL present the head entry on trace_data, combinationally from FIFO storage, with zero-cycle read latency.
- REQ-029 SHALL wrap the FIFO read and write pointers modulo TRACE_DEPTH.

Reset
- REQ-030 SHALL, while reset=0 (asynchronously), force state=IDLE, cycle counter=0, FIFO empty, overflow=0, trace_valid=0, running=0, done=0 and cpu_reset=1.
- REQ-031 SHALL, when reset is asserted mid-run, abandon the run and discard all trace contents.

Configuration
- REQ-032 SHALL, with MCC_RUN_CTRL_TIMESTAMP_EN defined, use TW=CYC_W+DATA_BUS_WIDTH, with trace_data = {RUN-cycle index since entering RUN (0-based), program_out}.
- REQ-033 SHALL, without MCC_RUN_CTRL_TIMESTAMP_EN, use TW=DATA_BUS_WIDTH, with trace_data = program_out only; behaviour is otherwise identical.

Structure
- REQ-034 SHALL take the state enumeration and the default parameter constants from the shared package mcc_run_pkg.
- REQ-035 SHALL implement the FIFO as the sub-module mcc_trace_fifo, with parameters WIDTH and DEPTH and push/pop/full/empty/overflow ports.

Verification
- REQ-036 SHALL cover: hold reset=0 for 3 cycles, then release -> cpu_reset=1, state IDLE, trace_valid=0, overflow=0.
- REQ-037 SHALL cover: start pulse with defaults -> cpu_reset=1 for exactly 5 cycles, 0 for exactly 401 cycles, then done=1 and cpu_reset=1.
- REQ-038 SHALL cover: program_out constant 0x0000_0007 throughout RUN with trace_ready=0 -> exactly one entry, 0x0000_0007 (timestamp 0 when MCC_RUN_CTRL_TIMESTAMP_EN is defined).
- REQ-039 SHALL cover: TRACE_DEPTH=4, program_out incrementing every cycle, trace_ready=0 -> four entries, values 0 to 3, and overflow=1; then trace_ready=1 -> four pops, trace_valid=0.
- REQ-040 SHALL cover: FIFO full, new value pushed while trace_ready=1 in the same cycle -> count stays 4, overflow stays 0.
- REQ-041 SHALL cover: reset=0 asserted at RUN cycle 100 -> IDLE immediately, FIFO empty, cpu_reset=1; a later start runs a complete fresh sequence.
